rggen_register_access_arbiter: RTL and testbench

Two-port arbiter that shares one register-file access bus between two bus requesters, for example a host bus adapter and a debug port. It sits between the requesters and the register blocks built from the rggen bit-field cells. It accepts one command at a time with round-robin priority, drives the shared register bus until the addressed register responds, and returns the response to the granted requester. Only one access is outstanding at any time.

---
 rtl/rggen_register_access_arbiter_pkg.sv | 22 ++
 rtl/rggen_register_access_arbiter_if.sv | 70 +++++++
 rtl/rggen_round_robin_arbiter_2.sv | 19 +
 rtl/rggen_register_access_arbiter.sv | 177 +++++++++++++++++
 tb/tb_rggen_register_access_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/rggen_register_access_arbiter_pkg.sv
// Shared encodings for the register access arbiter and its bus adapters.
// FSM states, response status codes and a small one-hot helper.
package rggen_register_access_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    RESPONSE = 2'd2
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  function automatic logic [1:0] idx_onehot(
    input logic idx
  );
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rggen_register_access_arbiter_if.sv
// Requester-side and shared register-bus signals of the access arbiter.
// master: the arbiter's view; slave: requesters plus register block.
interface rggen_register_access_arbiter_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);

  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [1:0]                 req_write;
  logic [2*ADDRESS_WIDTH-1:0] req_address;
  logic [2*DATA_WIDTH-1:0]    req_write_data;
  logic [2*DATA_WIDTH-1:0]    req_strobe;
  logic [1:0]                 resp_valid;
  logic [1:0]                 resp_ready;
  logic [1:0]                 resp_status;
  logic [DATA_WIDTH-1:0]      resp_read_data;

  logic                       register_valid;
  logic                       register_write;
  logic [ADDRESS_WIDTH-1:0]   register_address;
  logic [DATA_WIDTH-1:0]      register_write_data;
  logic [DATA_WIDTH-1:0]      register_strobe;
  logic                       register_ready;
  logic [1:0]                 register_status;
  logic [DATA_WIDTH-1:0]      register_read_data;

  modport master (
    input  req_valid,
    output req_ready,
    input  req_write,
    input  req_address,
    input  req_write_data,
    input  req_strobe,
    output resp_valid,
    input  resp_ready,
    output resp_status,
    output resp_read_data,
    output register_valid,
    output register_write,
    output register_address,
    output register_write_data,
    output register_strobe,
    input  register_ready,
    input  register_status,
    input  register_read_data
  );

  modport slave (
    output req_valid,
    input  req_ready,
    output req_write,
    output req_address,
    output req_write_data,
    output req_strobe,
    input  resp_valid,
    output resp_ready,
    input  resp_status,
    input  resp_read_data,
    input  register_valid,
    input  register_write,
    input  register_address,
    input  register_write_data,
    input  register_strobe,
    output register_ready,
    output register_status,
    output register_read_data
  );

endinterface

// File: rtl/rggen_round_robin_arbiter_2.sv
// Two-way round-robin grant: the requester that did not win last time
// has priority; a lone requester always wins.
module rggen_round_robin_arbiter_2 (
  input  logic [1:0] i_request,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    unique case (1'b1)
      (i_request == 2'b11): o_grant = i_last_grant ? 2'b01 : 2'b10;
      (i_request == 2'b01): o_grant = 2'b01;
      (i_request == 2'b10): o_grant = 2'b10;
      default:              o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/rggen_register_access_arbiter.sv
// Shares one register bus between two requesters, one access at a time.
// Optional watchdog: RGGEN_REGISTER_ACCESS_ARBITER_TIMEOUT_EN.
module rggen_register_access_arbiter
  import rggen_register_access_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
)(
  input logic                             i_clk,
  input logic                             i_rst,
  rggen_register_access_arbiter_if.master bus_if
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;

  if (TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e          state_q;
  state_e          state_d;
  logic            last_q;
  logic            last_d;
  logic            sel_q;
  logic            sel_d;
  logic            valid_q;
  logic            valid_d;
  logic            write_q;
  logic            write_d;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   addr_d;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   wdata_d;
  logic [DW-1:0]   strobe_q;
  logic [DW-1:0]   strobe_d;
  logic [1:0]      resp_valid_q;
  logic [1:0]      resp_valid_d;
  logic [1:0]      status_q;
  logic [1:0]      status_d;
  logic [DW-1:0]   rdata_q;
  logic [DW-1:0]   rdata_d;

  logic [1:0]      grant;
  logic [1:0]      req_ready;
  logic            gidx;

`ifdef RGGEN_REGISTER_ACCESS_ARBITER_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
`endif

  rggen_round_robin_arbiter_2 u_rr (
    .i_request    (bus_if.req_valid),
    .i_last_grant (last_q),
    .o_grant      (grant)
  );

  assign gidx      = grant[1];
  assign req_ready = (state_q == IDLE) ? grant : 2'b00;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    sel_d        = sel_q;
    valid_d      = valid_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strobe_d     = strobe_q;
    resp_valid_d = resp_valid_q;
    status_d     = status_q;
    rdata_d      = rdata_q;
`ifdef RGGEN_REGISTER_ACCESS_ARBITER_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|(bus_if.req_valid & req_ready)) begin
          state_d  = ACCESS;
          last_d   = gidx;
          sel_d    = gidx;
          valid_d  = 1'b1;
          write_d  = bus_if.req_write[gidx];
          addr_d   = gidx ? bus_if.req_address[2*AW-1:AW]
                          : bus_if.req_address[AW-1:0];
          wdata_d  = gidx ? bus_if.req_write_data[2*DW-1:DW]
                          : bus_if.req_write_data[DW-1:0];
          strobe_d = gidx ? bus_if.req_strobe[2*DW-1:DW]
                          : bus_if.req_strobe[DW-1:0];
`ifdef RGGEN_REGISTER_ACCESS_ARBITER_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      ACCESS: begin
        // A real completion always wins over the watchdog.
        if (bus_if.register_ready) begin
          state_d      = RESPONSE;
          valid_d      = 1'b0;
          resp_valid_d = idx_onehot(sel_q);
          status_d     = bus_if.register_status;
          rdata_d      = write_q ? '0 : bus_if.register_read_data;
        end
`ifdef RGGEN_REGISTER_ACCESS_ARBITER_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d      = RESPONSE;
          valid_d      = 1'b0;
          resp_valid_d = idx_onehot(sel_q);
          status_d     = SLVERR;
          rdata_d      = '0;
        end else begin
          cnt_d        = cnt_q + CW'(1);
        end
`endif
      end
      RESPONSE: begin
        if (bus_if.resp_ready[sel_q]) begin
          state_d      = IDLE;
          resp_valid_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      sel_q        <= 1'b0;
      valid_q      <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strobe_q     <= '0;
      resp_valid_q <= 2'b00;
      status_q     <= OKAY;
      rdata_q      <= '0;
`ifdef RGGEN_REGISTER_ACCESS_ARBITER_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      sel_q        <= sel_d;
      valid_q      <= valid_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strobe_q     <= strobe_d;
      resp_valid_q <= resp_valid_d;
      status_q     <= status_d;
      rdata_q      <= rdata_d;
`ifdef RGGEN_REGISTER_ACCESS_ARBITER_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign bus_if.req_ready           = req_ready;
  assign bus_if.resp_valid          = resp_valid_q;
  assign bus_if.resp_status         = status_q;
  assign bus_if.resp_read_data      = rdata_q;
  assign bus_if.register_valid      = valid_q;
  assign bus_if.register_write      = write_q;
  assign bus_if.register_address    = addr_q;
  assign bus_if.register_write_data = wdata_q;
  assign bus_if.register_strobe     = strobe_q;

endmodule

// File: tb/tb_rggen_register_access_arbiter.sv
// Randomized bench for the register access arbiter with a
// transaction-level reference model of grant order and responses.
module tb_rggen_register_access_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int AW2 = 2 * AW;
  localparam int TO  = 4;
`ifdef RGGEN_REGISTER_ACCESS_ARBITER_TIMEOUT_EN
  localparam int LAT_MAX = TO + 2;
`else
  localparam int LAT_MAX = 6;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rggen_register_access_arbiter_if #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW)
  ) bus_if ();

  rggen_register_access_arbiter #(
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus_if (bus_if)
  );

  int n_checks;
  int n_errors;
  int last;

  logic          cw [2];
  logic [AW-1:0] ca [2];
  logic [DW-1:0] cd [2];
  logic [DW-1:0] cs [2];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic new_cmds();
    for (int i = 0; i < 2; i++) begin
      cw[i] = 1'($urandom);
      ca[i] = AW'($urandom);
      cd[i] = $urandom;
      cs[i] = $urandom;
    end
  endtask

  task automatic drive_cmds();
    bus_if.req_write      = {cw[1], cw[0]};
    bus_if.req_address    = {ca[1], ca[0]};
    bus_if.req_write_data = {cd[1], cd[0]};
    bus_if.req_strobe     = {cs[1], cs[0]};
  endtask

  task automatic scramble();
    bus_if.req_write          = 2'($urandom);
    bus_if.req_address        = AW2'($urandom);
    bus_if.req_write_data     = {$urandom, $urandom};
    bus_if.req_strobe         = {$urandom, $urandom};
    bus_if.register_status    = 2'($urandom);
    bus_if.register_read_data = $urandom;
  endtask

  task automatic run_access(input logic [1:0] vm, input int gap,
                            input int lat, input int bp,
                            input bit rst_mid, input logic [1:0] r_st,
                            input logic [DW-1:0] r_rd);
    int            idx;
    logic [1:0]    exp_st;
    logic [DW-1:0] exp_rd;
    exp_st = 2'b00;
    exp_rd = '0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bus_if.req_valid      = 2'b00;
      scramble();
      bus_if.register_ready = 1'($urandom);
      bus_if.resp_ready     = 2'($urandom);
      #1;
      check("idle_req_ready", bus_if.req_ready, 2'b00);
      check("idle_reg_valid", bus_if.register_valid, 1'b0);
      check("idle_resp_valid", bus_if.resp_valid, 2'b00);
    end
    @(negedge clk);
    bus_if.req_valid      = vm;
    drive_cmds();
    bus_if.register_ready = 1'($urandom);
    bus_if.resp_ready     = 2'($urandom);
    #1;
    idx = (vm == 2'b11) ? 1 - last : (vm[1] ? 1 : 0);
    check("grant", bus_if.req_ready, 2'b01 << idx);
    check("grant_reg_valid", bus_if.register_valid, 1'b0);
    last = idx;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      bus_if.req_valid      = 2'($urandom);
      scramble();
      bus_if.resp_ready     = 2'($urandom);
      bus_if.register_ready = (k == lat) && !rst_mid;
      if (k == lat) begin
        bus_if.register_status    = r_st;
        bus_if.register_read_data = r_rd;
      end
      #1;
      check("bus_valid", bus_if.register_valid, 1'b1);
      check("bus_write", bus_if.register_write, cw[idx]);
      check("bus_address", bus_if.register_address, ca[idx]);
      check("bus_wdata", bus_if.register_write_data, cd[idx]);
      check("bus_strobe", bus_if.register_strobe, cs[idx]);
      check("access_req_ready", bus_if.req_ready, 2'b00);
      check("access_resp_valid", bus_if.resp_valid, 2'b00);
      if (rst_mid) begin
        rst = 1'b1;
        @(negedge clk);
        rst                   = 1'b0;
        bus_if.req_valid      = 2'b00;
        bus_if.register_ready = 1'b0;
        #1;
        check("rst_reg_valid", bus_if.register_valid, 1'b0);
        check("rst_resp_valid", bus_if.resp_valid, 2'b00);
        check("rst_req_ready", bus_if.req_ready, 2'b00);
        last = 1;
        return;
      end
      if (k == lat) begin
        exp_st = r_st;
        exp_rd = cw[idx] ? '0 : r_rd;
      end
`ifdef RGGEN_REGISTER_ACCESS_ARBITER_TIMEOUT_EN
      else if (k == TO) begin
        exp_st = 2'b10;
        exp_rd = '0;
        break;
      end
`endif
    end
    for (int b = 0; b <= bp; b++) begin
      @(negedge clk);
      bus_if.req_valid      = 2'($urandom);
      scramble();
      bus_if.register_ready = 1'($urandom);
      bus_if.resp_ready     = 2'($urandom);
      bus_if.resp_ready[idx] = (b == bp);
      #1;
      check("resp_valid", bus_if.resp_valid, 2'b01 << idx);
      check("resp_status", bus_if.resp_status, exp_st);
      check("resp_rdata", bus_if.resp_read_data, exp_rd);
      check("resp_req_ready", bus_if.req_ready, 2'b00);
      check("resp_reg_valid", bus_if.register_valid, 1'b0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    last     = 1;
    rst      = 1'b1;
    bus_if.req_valid      = 2'b00;
    bus_if.resp_ready     = 2'b00;
    bus_if.register_ready = 1'b0;
    scramble();
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready0", bus_if.req_ready, 2'b00);
    check("rst_reg_valid0", bus_if.register_valid, 1'b0);
    check("rst_resp_valid0", bus_if.resp_valid, 2'b00);
    check("rst_reg_write0", bus_if.register_write, 1'b0);
    check("rst_reg_addr0", bus_if.register_address, '0);
    check("rst_reg_wdata0", bus_if.register_write_data, '0);
    check("rst_reg_strobe0", bus_if.register_strobe, '0);
    check("rst_resp_status0", bus_if.resp_status, 2'b00);
    check("rst_resp_rdata0", bus_if.resp_read_data, '0);
    rst = 1'b0;

    new_cmds();
    cw[0] = 1'b0;
    ca[0] = 8'h10;
    run_access(2'b01, 0, 2, 0, 1'b0, 2'b00, 32'hDEADBEEF);

    new_cmds();
    cw[1] = 1'b1;
    cd[1] = 32'h12345678;
    cs[1] = 32'h0000FFFF;
    run_access(2'b10, 1, 3, 0, 1'b0, 2'b00, 32'hFFFFFFFF);

    new_cmds();
    run_access(2'b11, 0, 1, 5, 1'b0, 2'b01, $urandom);

    new_cmds();
    run_access(2'b11, 0, 3, 0, 1'b1, 2'b00, '0);

    repeat (4) begin
      new_cmds();
      run_access(2'b11, 0, $urandom_range(1, 3), 0, 1'b0,
                 2'($urandom), $urandom);
    end

`ifdef RGGEN_REGISTER_ACCESS_ARBITER_TIMEOUT_EN
    new_cmds();
    cw[0] = 1'b0;
    run_access(2'b01, 0, TO + 3, 0, 1'b0, 2'b00, 32'hA5A5A5A5);
    new_cmds();
    cw[1] = 1'b0;
    run_access(2'b10, 0, TO, 1, 1'b0, 2'b11, 32'h5A5A5A5A);
    new_cmds();
    run_access(2'b01, 0, TO - 1, 0, 1'b0, 2'b01, $urandom);
`endif

    repeat (60) begin
      new_cmds();
      run_access(2'($urandom_range(1, 3)), $urandom_range(0, 2),
                 $urandom_range(1, LAT_MAX), $urandom_range(0, 3), 1'b0,
                 2'($urandom), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
